// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared constants for the RV32M multiply/divide unit.
//   FUNCT7_MULDIV      funct7 value that marks an M-extension R-type op
//   FUNCT3_*           operation encodings carried on funct3
//   muldiv_state_t     FSM state encoding (IDLE=0, CALC=1, FIX=2, DONE=3)
package muldiv_unit_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_step.sv
// muldiv_step: one combinational iteration of the iterative datapath.
//   is_div    0: shift-add multiply step, 1: restoring divide step
//   acc       current 2*XLEN accumulator
//               multiply: {partial product high, multiplier / product low}
//               divide:   {partial remainder, dividend / quotient}
//   opb       multiplicand (multiply) or divisor (divide), magnitude only
//   acc_next  accumulator after this iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    // Multiply: add multiplicand to the high half when the current
    // multiplier bit is set, then shift the whole accumulator right,
    // pulling the add's carry in at the top.
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);

    // Divide: shift the next dividend bit into the partial remainder and
    // trial-subtract. The shifted remainder needs XLEN+1 bits; the kept
    // remainder always fits XLEN bits because it is below the divisor.
    shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, opb};

    if (is_div) begin
      if (diff[XLEN+1]) begin
        acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
//   clock    system clock, rising edge
//   reset    asynchronous active-high reset
//   start    request, sampled only in IDLE
//   flush    synchronous abort; wins over start and over the done pulse
//   funct3   MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1/rs2  operand A (dividend / multiplicand), operand B (divisor / multiplier)
//   busy     high whenever the FSM is not IDLE
//   done     one-cycle pulse, result valid in this cycle
//   result   result register, holds until the next done
// Handshake: start is accepted only on an edge where busy=0 and flush=0;
// the matching result appears exactly in the one cycle where done=1.
// Configuration macro: MULDIV_FAST_MUL_EN selects a single-cycle 33x33
// signed multiplier for multiply ops (divides keep the 34-cycle loop).
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITER);

  muldiv_state_t     state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_step;
  logic [XLEN-1:0]   opb_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   result_q;

  // FSM control / write strobes
  logic              load;
  logic              write_res;
  logic [XLEN-1:0]   res_d;

  // Operand decode used while IDLE
  logic              in_div, sa, sb, neg_in, div_zero, div_ovf;
  logic [XLEN-1:0]   abs_a, abs_b, special_val;

  // Sign fix-up of the finished loop
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_field, fix_val;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  logic [XLEN-1:0]          fast_val;
`endif

  always_comb begin
    in_div = funct3[2];
    sa = rs1[XLEN-1] & ((funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU) ||
                        (funct3 == FUNCT3_DIV)  || (funct3 == FUNCT3_REM));
    sb = rs2[XLEN-1] & ((funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_DIV) ||
                        (funct3 == FUNCT3_REM));
    abs_a = sa ? (~rs1 + 1'b1) : rs1;
    abs_b = sb ? (~rs2 + 1'b1) : rs2;
    // Remainder takes the dividend's sign; product and quotient take sA^sB.
    neg_in = (funct3 == FUNCT3_REM) ? sa : (sa ^ sb);

    div_zero = in_div && (rs2 == '0);
    div_ovf  = ((funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM)) &&
               (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    if (div_zero) begin
      special_val = funct3[1] ? rs1 : '1;
    end else begin
      special_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    // MULHSU and MULHU zero-extend rs2; MULHU also zero-extends rs1.
    fast_prod = $signed({(funct3 != FUNCT3_MULHU) & rs1[XLEN-1], rs1}) *
                $signed({((funct3 == FUNCT3_MUL) || (funct3 == FUNCT3_MULH)) & rs2[XLEN-1], rs2});
    fast_val  = (funct3 == FUNCT3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (op_q[2]),
    .acc      (acc_q),
    .opb      (opb_q),
    .acc_next (acc_step)
  );

  always_comb begin
    prod      = neg_q ? (~acc_q + 1'b1) : acc_q;
    div_field = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (op_q[2]) begin
      fix_val = neg_q ? (~div_field + 1'b1) : div_field;
    end else if (op_q == FUNCT3_MUL) begin
      fix_val = prod[XLEN-1:0];
    end else begin
      fix_val = prod[2*XLEN-1:XLEN];
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and outputs
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    write_res = 1'b0;
    res_d     = result_q;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          if (div_zero || div_ovf) begin
            state_d   = ST_DONE;
            write_res = 1'b1;
            res_d     = special_val;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!in_div) begin
            state_d   = ST_DONE;
            write_res = 1'b1;
            res_d     = fast_val;
`endif
          end else begin
            state_d = ST_CALC;
            load    = 1'b1;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // A flush here suppresses the upcoming done pulse and result write.
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_DONE;
          write_res = 1'b1;
          res_d     = fix_val;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      if (load) begin
        // Divide: dividend in the low half, divisor in opb.
        // Multiply: multiplier in the low half, multiplicand in opb.
        acc_q <= {{XLEN{1'b0}}, (in_div ? abs_a : abs_b)};
        opb_q <= in_div ? abs_b : abs_a;
        op_q  <= funct3;
        neg_q <= neg_in;
        cnt_q <= CW'(ITER - 1);
      end else if (state_q == ST_CALC) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - 1'b1;
      end
      if (write_res) begin
        result_q <= res_d;
      end
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_unit dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          t0_q[$];
  logic [31:0] last_res = '0;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p, ua, ub;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from the accepting edge to the done cycle, counting the done cycle.
  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2]) begin
      if (b == 0) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 34;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 34;
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        int l, t0;
        e  = exp_q.pop_front();
        l  = lat_q.pop_front();
        t0 = t0_q.pop_front();
        check("result", result, e);
        check("latency", 32'(cyc - t0 + 1), 32'(l));
        check("busy_with_done", {31'b0, busy}, 32'd1);
        last_res = e;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit push);
    int guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    if (guard >= 200) check("issue_timeout", 32'd1, 32'd0);
    funct3 = f3; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    if (push) begin
      exp_q.push_back(model(f3, a, b));
      lat_q.push_back(model_lat(f3, a, b));
      t0_q.push_back(cyc);
    end
  endtask

  task automatic wait_all();
    int guard = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && guard < 300) begin
      @(posedge clock); #1;
      guard++;
    end
    if (guard >= 300) check("drain_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed vectors, issued back-to-back.
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 1);
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    issue(3'd4, 32'hFFFFFFEC, 32'd6, 1);
    issue(3'd6, 32'hFFFFFFEC, 32'd6, 1);
    issue(3'd5, 32'd100, 32'd7, 1);
    issue(3'd5, 32'd5, 32'd0, 1);
    issue(3'd6, 32'd5, 32'd0, 1);
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 1);
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 1);
    issue(3'd1, 32'h80000000, 32'h80000000, 1);
    wait_all();

    // Randomized operations with a mix of edge operands.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int sel;
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) a = 32'($urandom_range(0, 15));
      issue(f3, a, b, 1);
    end
    wait_all();

    // Flush in the middle of a divide: no done, result held.
    issue(3'd4, 32'd1000, 32'd3, 0);
    repeat (9) @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_result_held", result, last_res);
    repeat (40) @(posedge clock);
    #1;
    check("flush_result_still_held", result, last_res);

    // Start held high while busy must not launch a second op.
    issue(3'd5, 32'd100, 32'd7, 1);
    funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
    repeat (20) @(posedge clock);
    #1 start = 1'b0;
    wait_all();
    repeat (5) @(posedge clock);
    #1;

    // Asynchronous reset in the middle of a multiply.
    issue(3'd0, 32'd1234, 32'd5678, 1);
    repeat (19) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_done", {31'b0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    exp_q.delete(); lat_q.delete(); t0_q.delete();
    last_res = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 1);
    issue(3'd7, 32'd100, 32'd7, 1);
    wait_all();
    repeat (3) @(posedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, alongside the ALU.
- Takes operands and funct3 when the decode/ALU-control path flags an M-extension R-type op (funct7 = FUNCT7_MULDIV).
- Holds the pipeline via busy and returns a 32-bit result with a one-cycle done pulse.
- The EX result mux selects result over the ALU output when done=1.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
ITER, 32, iteration count of the shift-add / restoring-divide loop (= XLEN)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
flush  input  1  synchronous abort (branch mispredict/exception)
funct3  input  3  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
rs1  input  32  operand A (dividend / multiplicand)
rs2  input  32  operand B (divisor / multiplier)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid this cycle only
result  output  32  result register; holds last value until next done

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, result=0, all internal registers 0.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE: when start=1 and flush=0 at edge N:
  - Latch funct3.
  - Latch |rs1|, |rs2| for signed forms: MULH and DIV/REM take both as signed; MULHSU takes only rs1 as signed.
  - Latch result sign: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
  - Load counter=ITER-1 and go to CALC.
- CALC: one iteration per cycle for ITER cycles (N+1..N+32); counter decrements and exits at 0.
  - Multiply: 64-bit accumulator, add-then-shift right.
  - Divide: restoring; 33-bit partial remainder; shift left, trial-subtract divisor, set quotient bit when non-negative.
- FIX (N+33): conditional two's-complement negate of the 64-bit product or quotient/remainder; select field:
  - MUL = low 32 bits.
  - MULH/MULHSU/MULHU = high 32 bits.
  - DIV/DIVU = quotient.
  - REM/REMU = remainder.
- DONE (N+34): result register written, done=1, busy=1; next cycle IDLE. Total latency start->done = 34 cycles.
- Special cases resolved at IDLE with no iterations; go directly to DONE, so done at N+1:
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- start while busy=1: ignored. No queueing; the upstream stall holds the instruction.
- flush: at the next edge state=IDLE, done stays 0, result unchanged. Flush wins over start in IDLE and over DONE (the done pulse is suppressed).
- Reset mid-operation: immediate return to the reset values; no done pulse.
- Back-to-back: a new start is accepted in the cycle after DONE (IDLE). One idle cycle minimum between ops.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - Multiply ops use a single-cycle 33x33 signed combinational product computed in IDLE.
  - State goes IDLE -> DONE, so done at N+1.
  - Divide path unchanged at 34 cycles.
- Undefined: all multiplies use the 32-iteration loop (34-cycle latency). No hardware multiplier is inferred.

Decomposition:
- constants.vh:
  - FUNCT7_MULDIV = 7'b0000001.
  - FUNCT3_MUL..FUNCT3_REMU encodings (0..7).
  - MULDIV state encodings (IDLE=0, CALC=1, FIX=2, DONE=3).
- config.vh: MULDIV_FAST_MUL_EN switch.
- One sub-module: muldiv_step, a combinational single-iteration datapath (add-shift for multiply, trial-subtract for divide). It is selected by an is_div flag and instantiated once; the FSM, counter and sign fix stay in muldiv_unit.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD), start at cycle 0 -> busy cycles 1..34, done at 34, result=0xFFFFFFEB. With MULDIV_FAST_MUL_EN: done at cycle 1.
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> result=0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU with the same operands -> 0xFFFFFFFF.
- DIV rs1=-20, rs2=6 -> result=0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFE (-2). DIVU rs1=100, rs2=7 -> 14.
- DIVU rs1=5, rs2=0 -> done at cycle 1, result=0xFFFFFFFF. REM rs1=5, rs2=0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1.
- Start DIV, assert flush at cycle 10 -> busy=0 at cycle 11, no done pulse, result keeps its previous value. start held during busy -> ignored.
- Assert reset at cycle 20 of a MUL -> busy, done and result = 0 immediately. New op issued after reset release completes normally.
